// File: rtl/bdf_sched_loader_pkg.sv
// Shared types and sizing for the BDF schedule loader.
package bdf_sched_loader_pkg;

    localparam int BDF_CTRL_WIDTH  = 24;
    localparam int BDF_ITER_PERIOD = 48;

    // Loader control states, exported on dbg_state for observation.
    typedef enum logic [2:0] {
        FILL  = 3'd0,
        FULL  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        RUN   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/bdf_sched_loader_if.sv
// Host-to-loader schedule stream.
// Valid/ready: a word moves on a rising edge where s_valid and s_ready are
// both high; s_data and s_last are meaningful only on that edge. The host
// holds s_valid/s_data/s_last until the transfer, the loader may drop
// s_ready at any time and never waits on s_valid before raising it.
interface bdf_sched_loader_if
    import bdf_sched_loader_pkg::*;
#(
    parameter int W = BDF_CTRL_WIDTH
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/bdf_sched_ram.sv
// Schedule storage: synchronous write, combinational read.
// Contents are not reset; a schedule is only trusted once fully loaded.
module bdf_sched_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 48
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write one schedule word per accepted host transfer.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/bdf_sched_loader.sv
// Collects one iteration schedule from the host, then on go replays it to
// the BDF array controller as a gapless load_ctrl burst followed by a
// start_ctrl pulse. halt becomes a single stop_ctrl pulse.
module bdf_sched_loader
    import bdf_sched_loader_pkg::*;
#(
    parameter int CTRL_WIDTH  = BDF_CTRL_WIDTH,
    parameter int ITER_PERIOD = BDF_ITER_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst,
    bdf_sched_loader_if.slave     s_if,
    input  logic                  go,
    input  logic                  halt,
    output logic                  load_ctrl,
    output logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic                  start_ctrl,
    output logic                  stop_ctrl,
    output logic                  busy,
    output logic                  err,
    output sched_state_t          dbg_state
);

    localparam int               CNT_W    = $clog2(ITER_PERIOD);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITER_PERIOD - 1);

    sched_state_t          r_state,   w_state_d;
    logic [CNT_W-1:0]      r_wr_cnt,  w_wr_cnt_d;
    logic [CNT_W-1:0]      r_rd_cnt,  w_rd_cnt_d;
    logic                  r_s_ready, w_s_ready_d;
    logic                  r_load,    w_load_d;
    logic [CTRL_WIDTH-1:0] r_ctrl,    w_ctrl_d;
    logic                  r_start,   w_start_d;
    logic                  r_stop,    w_stop_d;
    logic                  r_busy,    w_busy_d;
    logic                  r_err,     w_err_d;

    logic                  w_xfer;
    logic                  w_we;
    logic [CNT_W-1:0]      w_rd_addr;
    logic [CTRL_WIDTH-1:0] w_rd_data;

    assign w_xfer = s_if.s_valid & r_s_ready;
    assign w_we   = w_xfer & (r_state == FILL);

    // The word registered into ctrl_in on the next edge: mem[0] when the
    // burst is launched from FULL, otherwise the word after the current one.
    assign w_rd_addr = (r_state == LOAD && r_rd_cnt != LAST_IDX) ? r_rd_cnt + 1'b1 : '0;

    bdf_sched_ram #(
        .WIDTH (CTRL_WIDTH),
        .DEPTH (ITER_PERIOD)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (s_if.s_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Next-state, counter and next-output decode; halt always beats go.
    always_comb begin
        w_state_d  = r_state;
        w_wr_cnt_d = r_wr_cnt;
        w_rd_cnt_d = r_rd_cnt;
        w_err_d    = r_err;
        w_load_d   = 1'b0;
        w_ctrl_d   = '0;
        w_start_d  = 1'b0;
        w_stop_d   = 1'b0;

        case (r_state)
            FILL: begin
                if (w_xfer) begin
                    if (r_wr_cnt == LAST_IDX && s_if.s_last) begin
                        w_state_d  = FULL;
                        w_wr_cnt_d = '0;
                    end else if (s_if.s_last || r_wr_cnt == LAST_IDX) begin
                        // Framing error: drop the partial schedule, start over.
                        w_err_d    = 1'b1;
                        w_wr_cnt_d = '0;
                    end else begin
                        w_wr_cnt_d = r_wr_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (halt) begin
                    w_state_d  = FILL;
                    w_wr_cnt_d = '0;
                end else if (go) begin
                    w_state_d  = LOAD;
                    w_rd_cnt_d = '0;
                    w_load_d   = 1'b1;
                    w_ctrl_d   = w_rd_data;
                end
            end
            LOAD: begin
                if (halt) begin
                    w_state_d = FULL;
                    w_stop_d  = 1'b1;
                end else if (r_rd_cnt == LAST_IDX) begin
                    w_state_d = START;
                    w_start_d = 1'b1;
                end else begin
                    w_rd_cnt_d = r_rd_cnt + 1'b1;
                    w_load_d   = 1'b1;
                    w_ctrl_d   = w_rd_data;
                end
            end
            START: begin
                if (halt) begin
                    w_state_d = FULL;
                    w_stop_d  = 1'b1;
                end else begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    w_state_d = FULL;
                    w_stop_d  = 1'b1;
                end
            end
            default: begin
                w_state_d  = FILL;
                w_wr_cnt_d = '0;
            end
        endcase

        w_busy_d    = (w_state_d == LOAD) || (w_state_d == START) || (w_state_d == RUN);
        w_s_ready_d = (w_state_d == FILL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FILL;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_s_ready <= 1'b0;
            r_load    <= 1'b0;
            r_ctrl    <= '0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_wr_cnt  <= w_wr_cnt_d;
            r_rd_cnt  <= w_rd_cnt_d;
            r_s_ready <= w_s_ready_d;
            r_load    <= w_load_d;
            r_ctrl    <= w_ctrl_d;
            r_start   <= w_start_d;
            r_stop    <= w_stop_d;
            r_busy    <= w_busy_d;
            r_err     <= w_err_d;
        end
    end

    assign s_if.s_ready = r_s_ready;
    assign load_ctrl    = r_load;
    assign ctrl_in      = r_ctrl;
    assign start_ctrl   = r_start;
    assign stop_ctrl    = r_stop;
    assign busy         = r_busy;
    assign err          = r_err;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_bdf_sched_loader.sv
// Directed/randomized bench for bdf_sched_loader with a queue-based model
// of the stored schedule and framing rules.
module tb_bdf_sched_loader;
    import bdf_sched_loader_pkg::*;

    localparam int CTRL_W = BDF_CTRL_WIDTH;
    localparam int IP     = BDF_ITER_PERIOD;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic go;
    logic halt;
    logic              load_ctrl;
    logic [CTRL_W-1:0] ctrl_in;
    logic              start_ctrl;
    logic              stop_ctrl;
    logic              busy;
    logic              err;
    sched_state_t      dbg_state;

    bdf_sched_loader_if #(.W(CTRL_W)) s_if ();

    bdf_sched_loader #(
        .CTRL_WIDTH  (CTRL_W),
        .ITER_PERIOD (IP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_if       (s_if),
        .go         (go),
        .halt       (halt),
        .load_ctrl  (load_ctrl),
        .ctrl_in    (ctrl_in),
        .start_ctrl (start_ctrl),
        .stop_ctrl  (stop_ctrl),
        .busy       (busy),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int total = 0;
    int bad   = 0;

    logic [CTRL_W-1:0] exp_q[$];   // schedule the loader should hold
    logic [CTRL_W-1:0] acc_q[$];   // words of the schedule being received
    bit m_full = 1'b0;
    bit m_err  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Schedule framing: exactly IP words with s_last on the last one.
    task automatic model_xfer(input logic [CTRL_W-1:0] d, input bit l);
        acc_q.push_back(d);
        if (l) begin
            if (acc_q.size() == IP) begin
                exp_q  = acc_q;
                m_full = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            acc_q.delete();
        end else if (acc_q.size() == IP) begin
            m_err = 1'b1;
            acc_q.delete();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_words(input int first, input int n, input int last_at,
                              input bit rnd, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            logic [CTRL_W-1:0] d;
            int budget;
            d = rnd ? CTRL_W'($urandom) : CTRL_W'(i * 32'h010101);
            if (gaps) begin
                s_if.s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            s_if.s_valid = 1'b1;
            s_if.s_data  = d;
            s_if.s_last  = (i == last_at);
            budget = 50;
            while (s_if.s_ready !== 1'b1 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            chk("ready_wait", 64'(budget > 0), 64'd1);
            @(negedge clk);
            s_if.s_valid = 1'b0;
            s_if.s_last  = 1'b0;
            if (budget > 0) model_xfer(d, i == last_at);
            chk("err", 64'(err), 64'(m_err));
            chk("s_ready", 64'(s_if.s_ready), 64'(!m_full));
            chk("fill_state", 64'(dbg_state), m_full ? 64'(FULL) : 64'(FILL));
        end
    endtask

    // go at edge N; optional halt or rst in the cycle of the k-th word.
    task automatic replay(input int halt_at, input int rst_at);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int c = 1; c <= IP; c++) begin
            chk("load_hi", 64'(load_ctrl), 64'd1);
            chk("ctrl_word", 64'(ctrl_in), 64'(exp_q[c-1]));
            chk("start_in_load", 64'(start_ctrl), 64'd0);
            chk("busy_load", 64'(busy), 64'd1);
            if (c == halt_at) begin
                halt = 1'b1;
                @(negedge clk);
                halt = 1'b0;
                chk("halt_load", 64'(load_ctrl), 64'd0);
                chk("halt_ctrl", 64'(ctrl_in), 64'd0);
                chk("halt_start", 64'(start_ctrl), 64'd0);
                chk("halt_stop", 64'(stop_ctrl), 64'd1);
                chk("halt_busy", 64'(busy), 64'd0);
                chk("halt_state", 64'(dbg_state), 64'(FULL));
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("halt_stop_once", 64'(stop_ctrl), 64'd0);
                    chk("halt_no_start", 64'(start_ctrl), 64'd0);
                    chk("halt_no_load", 64'(load_ctrl), 64'd0);
                end
                return;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_s_ready", 64'(s_if.s_ready), 64'd0);
                chk("rst_load", 64'(load_ctrl), 64'd0);
                chk("rst_ctrl", 64'(ctrl_in), 64'd0);
                chk("rst_start", 64'(start_ctrl), 64'd0);
                chk("rst_stop", 64'(stop_ctrl), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_err", 64'(err), 64'd0);
                chk("rst_state", 64'(dbg_state), 64'(FILL));
                rst    = 1'b0;
                m_full = 1'b0;
                m_err  = 1'b0;
                acc_q.delete();
                @(negedge clk);
                chk("rst_ready_rise", 64'(s_if.s_ready), 64'd1);
                return;
            end
            go = (c == 5);  // go mid-burst must not restart it
            @(negedge clk);
            go = 1'b0;
        end
        chk("end_load", 64'(load_ctrl), 64'd0);
        chk("end_ctrl", 64'(ctrl_in), 64'd0);
        chk("start_pulse", 64'(start_ctrl), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("start_once", 64'(start_ctrl), 64'd0);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_state", 64'(dbg_state), 64'(RUN));
    endtask

    task automatic halt_in_run();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("run_go_ignored", 64'(dbg_state), 64'(RUN));
        chk("run_go_no_load", 64'(load_ctrl), 64'd0);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("run_stop", 64'(stop_ctrl), 64'd1);
        chk("run_halt_busy", 64'(busy), 64'd0);
        chk("run_halt_state", 64'(dbg_state), 64'(FULL));
        chk("run_halt_ready", 64'(s_if.s_ready), 64'd0);
        @(negedge clk);
        chk("run_stop_once", 64'(stop_ctrl), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        go = 1'b0;
        halt = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", 64'(s_if.s_ready), 64'd0);
        chk("reset_load", 64'(load_ctrl), 64'd0);
        chk("reset_ctrl", 64'(ctrl_in), 64'd0);
        chk("reset_start", 64'(start_ctrl), 64'd0);
        chk("reset_stop", 64'(stop_ctrl), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(FILL));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(s_if.s_ready), 64'd1);

        // 1: ramp schedule, replay, start.
        send_words(0, IP, IP - 1, 1'b0, 1'b0);
        chk("full_after_fill", 64'(dbg_state), 64'(FULL));
        replay(0, 0);

        // 2: halt in RUN, relaunch identical schedule.
        halt_in_run();
        replay(0, 0);
        halt_in_run();

        // Discard via go+halt so scenario 3 starts from FILL.
        go = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        go = 1'b0;
        halt = 1'b0;
        m_full = 1'b0;
        chk("discard_state", 64'(dbg_state), 64'(FILL));

        // 3: early s_last, then a clean schedule with a halt inside FILL.
        send_words(0, 10, 9, 1'b1, 1'b0);
        chk("early_last_err", 64'(err), 64'd1);
        send_words(0, 20, -1, 1'b1, 1'b1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("fill_halt_ignored", 64'(dbg_state), 64'(FILL));
        chk("fill_halt_ready", 64'(s_if.s_ready), 64'd1);
        send_words(20, IP - 20, IP - 1, 1'b1, 1'b1);
        chk("err_sticky", 64'(err), 64'd1);

        // 4: halt at the 20th load word.
        replay(20, 0);

        // 5: go and halt together in FULL discard the schedule.
        go = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        go = 1'b0;
        halt = 1'b0;
        m_full = 1'b0;
        chk("go_halt_state", 64'(dbg_state), 64'(FILL));
        chk("go_halt_ready", 64'(s_if.s_ready), 64'd1);
        chk("go_halt_no_load", 64'(load_ctrl), 64'd0);
        @(negedge clk);
        chk("go_halt_no_load2", 64'(load_ctrl), 64'd0);
        send_words(0, IP, IP - 1, 1'b0, 1'b1);
        replay(0, 0);
        halt_in_run();

        // 6: reset mid-burst, then a go with nothing stored.
        replay(0, 30);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stale_go_load", 64'(load_ctrl), 64'd0);
            chk("stale_go_state", 64'(dbg_state), 64'(FILL));
            @(negedge clk);
        end

        // Recovery with a random schedule and an overlong frame first.
        send_words(0, IP, -1, 1'b1, 1'b0);
        chk("overlong_err", 64'(err), 64'd1);
        send_words(0, IP, IP - 1, 1'b1, 1'b1);
        replay(0, 0);
        halt_in_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
